eject_reduce_unit: RTL and testbench
====================================

Name: eject_reduce_unit

Overview:
- Sits directly downstream of the router's eject port and consumes the `eject_xpos` / `eject_xpos_valid` flit stream.
- Pass-through flits are forwarded to the host.
- Reduction flits (MPI reduce/allreduce contributions) are accumulated per tag until the configured contribution count arrives. One result flit is then emitted to the host.
- Output is buffered in a small FIFO with ready/valid toward the host. The eject side has no backpressure, so the unit accepts a flit every cycle.

Parameters:
- FLIT_W, 82, flit width (matches router ports).
- N_SLOTS, 4, accumulator slots (power of 2); slot index = tag[log2(N_SLOTS)-1:0].
- FIFO_DEPTH, 4, host output FIFO entries (power of 2).
- NODE_ID, 8'd0, src id written into result flits.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- eject_xpos  in  82  flit from router eject port.
- eject_xpos_valid  in  1  flit valid; always accepted.
- cfg_expected  in  8  contributions per reduction; 0 treated as 1.
- host_flit  out  82  head of output FIFO.
- host_valid  out  1  FIFO non-empty.
- host_ready  in  1  host pops when host_valid && host_ready.
- drop_err  out  1  sticky: a flit was dropped on FIFO overflow.
- busy  out  1  any slot has count != 0.

Behaviour:
- Flit fields:
  - [81] flit marker, must be 1.
  - [80:77] opcode.
  - [76:69] src.
  - [68:61] dst.
  - [60:53] tag.
  - [52:32] reserved.
  - [31:0] payload.
- Input validity: a flit with eject_xpos_valid=1 and [81]=0 is ignored (no state change).
- Opcodes:
  - 4'h0 PASS.
  - 4'h1 RSUM.
  - 4'h2 RMAX.
  - Any other value is treated as PASS.
- Reset (rst=0, async): all slot counts and accumulators = 0, FIFO empty, host_valid=0, host_flit=0, drop_err=0, busy=0.
- PASS: the flit is pushed unmodified into the FIFO at the sampling edge. host_valid is 1 the next cycle if the FIFO was empty (1-cycle latency).
- RSUM/RMAX, slot s = tag low bits. Read-modify-write completes in the sampling cycle; slot state is registers with combinational read, so back-to-back same-tag flits need no stall or hazard logic.
  - count==0: acc <= payload, count <= 1.
  - Otherwise: acc <= acc+payload (mod 2^32) for RSUM, or max(acc,payload) unsigned for RMAX; count <= count+1.
  - Opcode for a slot is taken from each flit and is not checked against earlier contributions.
- Completion: when the new count == max(cfg_expected,1):
  - Push result flit: [81]=1, opcode of incoming flit, src=NODE_ID, dst and tag from incoming flit, reserved=0, payload = new acc value.
  - Clear the slot (count=0, acc=0) at the same edge.
  - Latency: last contribution sampled at edge k → host_valid by k+1 if FIFO was empty.
- Tag aliasing: tags sharing low bits share a slot. This is a software contract; hardware does not detect it.
- cfg_expected change with contributions pending: comparison uses the current value. If count already exceeds the new value, the slot completes only when the 8-bit count wraps to equality, so software must change it only when busy=0.
- At most one FIFO push per cycle (one input per cycle).
- FIFO push/pop in the same cycle:
  - Allowed when not empty.
  - When full with a pop, the push is accepted and occupancy is unchanged.
  - When full without a pop, the push is dropped, drop_err <= 1 (sticky until reset), and slot state still updates and clears as normal.
- Pop when empty: no effect.
- host_flit: registered FIFO head, stable while host_valid && !host_ready.

Decomposition:
- Shared package:
  - FLIT_W.
  - Field bit-position constants.
  - Opcode constants (OP_PASS, OP_RSUM, OP_RMAX).
  - A flit-build helper function used by both this block and the inject-side generator.
- One natural sub-module, `flit_fifo`: parameterised FLIT_W x FIFO_DEPTH, synchronous FIFO with async active-low reset; push/pop/full/empty.
- Accumulator slots and completion logic stay in the top module.

Test Plan:
- PASS forward: after reset, inject flit {1,op0,src 8'h03,dst 8'h01,tag 0,payload 32'h6}, host_ready=1 → identical flit on host_flit the next cycle with host_valid=1 for exactly 1 cycle.
- RSUM complete: cfg_expected=4; tag 5, payloads 6, 5, 4, 3 on consecutive cycles → one result flit with payload 18, tag 5, src NODE_ID, one cycle after the 4th flit; busy=1 during the sequence, busy=0 after.
- RMAX plus interleaved tags: cfg_expected=2; tag1 payload 9, tag2 payload 7, tag1 payload 3, tag2 payload 11 → results tag1=9 then tag2=11, in that order.
- Overflow: host_ready=0, FIFO_DEPTH=4; 5 PASS flits → first 4 retained in order, drop_err=1. Raise host_ready → exactly 4 pops, then host_valid=0.
- Full with simultaneous pop: fill FIFO, then push while host_ready=1 → no drop, drop_err stays 0.
- Reset mid-reduction: 2 of 4 RSUM contributions to tag 0, assert rst=0 mid-cycle → outputs 0 immediately. After release, 4 new contributions of 1 → result payload 4 (no stale partial sum).

Source files
------------

// File: rtl/eject_reduce_unit_pkg.sv
// Shared flit layout, opcodes and the flit-build helper used on both the
// eject-side reduce unit and the inject-side generator.
package eject_reduce_unit_pkg;

  localparam int FLIT_W   = 82;

  localparam int MARK_BIT = 81;
  localparam int OP_HI    = 80;
  localparam int OP_LO    = 77;
  localparam int SRC_HI   = 76;
  localparam int SRC_LO   = 69;
  localparam int DST_HI   = 68;
  localparam int DST_LO   = 61;
  localparam int TAG_HI   = 60;
  localparam int TAG_LO   = 53;
  localparam int RSV_HI   = 52;
  localparam int RSV_LO   = 32;
  localparam int PAY_HI   = 31;
  localparam int PAY_LO   = 0;

  localparam logic [3:0] OP_PASS = 4'h0;
  localparam logic [3:0] OP_RSUM = 4'h1;
  localparam logic [3:0] OP_RMAX = 4'h2;

  // Builds a well-formed flit: marker set, reserved bits zero.
  function automatic logic [FLIT_W-1:0] build_flit(
    input logic [3:0]  op,
    input logic [7:0]  src,
    input logic [7:0]  dst,
    input logic [7:0]  tag,
    input logic [31:0] payload
  );
    logic [FLIT_W-1:0] f;
    f                = '0;
    f[MARK_BIT]      = 1'b1;
    f[OP_HI:OP_LO]   = op;
    f[SRC_HI:SRC_LO] = src;
    f[DST_HI:DST_LO] = dst;
    f[TAG_HI:TAG_LO] = tag;
    f[PAY_HI:PAY_LO] = payload;
    return f;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Synchronous flit FIFO with registered storage; head is read straight from
// the storage array so it stays stable until popped.
module flit_fifo #(
  parameter int FLIT_W = 82,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [FLIT_W-1:0] push_data,
  input  logic              pop,
  output logic [FLIT_W-1:0] head,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/eject_reduce_unit.sv
// Eject-side reduce unit: forwards pass-through flits and folds reduction
// contributions per tag slot, emitting one result flit per completed reduction.
module eject_reduce_unit
  import eject_reduce_unit_pkg::*;
#(
  parameter int         N_SLOTS    = 4,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] NODE_ID    = 8'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] eject_xpos,
  input  logic              eject_xpos_valid,
  input  logic [7:0]        cfg_expected,
  output logic [FLIT_W-1:0] host_flit,
  output logic              host_valid,
  input  logic              host_ready,
  output logic              drop_err,
  output logic              busy
);

  // Host handshake: host_flit/host_valid hold until the cycle where
  // host_valid && host_ready, which pops the head at that clock edge.
  // The eject side has no ready: every valid flit is sampled.

  localparam int SLOT_W = $clog2(N_SLOTS);

  logic [7:0]  cnt_q [N_SLOTS];
  logic [31:0] acc_q [N_SLOTS];

  logic [3:0]        in_op;
  logic [7:0]        in_dst;
  logic [7:0]        in_tag;
  logic [31:0]       in_pay;
  logic [SLOT_W-1:0] slot;
  logic              in_ok;
  logic              is_red;
  logic [7:0]        cur_cnt;
  logic [31:0]       cur_acc;
  logic [7:0]        new_cnt;
  logic [31:0]       new_acc;
  logic [7:0]        exp_eff;
  logic              done;
  logic              push;
  logic [FLIT_W-1:0] push_data;
  logic              fifo_empty;
  logic              fifo_full;

  assign in_op  = eject_xpos[OP_HI:OP_LO];
  assign in_dst = eject_xpos[DST_HI:DST_LO];
  assign in_tag = eject_xpos[TAG_HI:TAG_LO];
  assign in_pay = eject_xpos[PAY_HI:PAY_LO];
  assign slot   = in_tag[SLOT_W-1:0];
  assign in_ok  = eject_xpos_valid && eject_xpos[MARK_BIT];
  assign is_red = (in_op == OP_RSUM) || (in_op == OP_RMAX);

  always_comb begin
    cur_cnt = cnt_q[slot];
    cur_acc = acc_q[slot];
    new_cnt = cur_cnt + 8'd1;
    if (cur_cnt == 8'd0)
      new_acc = in_pay;
    else if (in_op == OP_RMAX)
      new_acc = (in_pay > cur_acc) ? in_pay : cur_acc;
    else
      new_acc = cur_acc + in_pay;
    exp_eff = (cfg_expected == 8'd0) ? 8'd1 : cfg_expected;
    done    = (new_cnt == exp_eff);
  end

  assign push      = in_ok && (!is_red || done);
  assign push_data = is_red ? build_flit(in_op, NODE_ID, in_dst, in_tag, new_acc)
                            : eject_xpos;

  // Slot state updates even if the result push is dropped on overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        cnt_q[i] <= '0;
        acc_q[i] <= '0;
      end
    end else if (in_ok && is_red) begin
      if (done) begin
        cnt_q[slot] <= '0;
        acc_q[slot] <= '0;
      end else begin
        cnt_q[slot] <= new_cnt;
        acc_q[slot] <= new_acc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop_err <= 1'b0;
    else if (push && fifo_full && !host_ready)
      drop_err <= 1'b1;
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) busy = busy | (cnt_q[i] != 8'd0);
  end

  flit_fifo #(
    .FLIT_W (FLIT_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (host_ready),
    .head      (host_flit),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign host_valid = !fifo_empty;

endmodule

// File: tb/tb_eject_reduce_unit.sv
// Bench for eject_reduce_unit: vector table of single flits plus hand-written
// reduction, overflow and reset sequences, with a host-side scoreboard.
module tb_eject_reduce_unit;

  localparam logic [7:0] NODE = 8'h5A;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [81:0] eject_xpos = '0;
  logic        eject_xpos_valid = 1'b0;
  logic [7:0]  cfg_expected = 8'd4;
  logic [81:0] host_flit;
  logic        host_valid;
  logic        host_ready = 1'b0;
  logic        drop_err;
  logic        busy;

  eject_reduce_unit #(
    .N_SLOTS    (4),
    .FIFO_DEPTH (4),
    .NODE_ID    (NODE)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .eject_xpos       (eject_xpos),
    .eject_xpos_valid (eject_xpos_valid),
    .cfg_expected     (cfg_expected),
    .host_flit        (host_flit),
    .host_valid       (host_valid),
    .host_ready       (host_ready),
    .drop_err         (drop_err),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  logic [81:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          pop_count = 0;
  logic [81:0] mon_exp;

  function automatic logic [81:0] mk(input logic [3:0] op, input logic [7:0] src,
                                     input logic [7:0] dst, input logic [7:0] tag,
                                     input logic [31:0] pay);
    return {1'b1, op, src, dst, tag, 21'd0, pay};
  endfunction

  task automatic check_flit(input string name, input logic [81:0] act, input logic [81:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst && host_valid && host_ready) begin
      pop_count++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_unexpected: got %h expected no output", host_flit);
      end else begin
        mon_exp = exp_q.pop_front();
        check_flit("scoreboard", host_flit, mon_exp);
      end
    end
  end

  task automatic drive(input logic [81:0] f, input logic v);
    @(posedge clk);
    #1;
    eject_xpos       = f;
    eject_xpos_valid = v;
  endtask

  task automatic send(input logic [81:0] f);
    drive(f, 1'b1);
  endtask

  task automatic idle();
    drive('0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst              = 1'b0;
    eject_xpos_valid = 1'b0;
    eject_xpos       = '0;
    host_ready       = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check_int("drain_empty", exp_q.size(), 0);
  endtask

  typedef struct {
    logic [81:0] flit;
    logic        valid;
    logic        exp_out;
  } vec_t;

  vec_t        vecs[7];
  logic [81:0] f;
  logic [81:0] pf[5];
  int          pc0;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Vector table.
    vecs[0] = '{mk(4'h0, 8'h03, 8'h01, 8'h00, 32'h6), 1'b1, 1'b1};
    f = mk(4'h0, 8'h11, 8'h22, 8'h01, 32'hDEAD_BEEF); f[81] = 1'b0;
    vecs[1] = '{f, 1'b1, 1'b0};
    vecs[2] = '{mk(4'h7, 8'h44, 8'h55, 8'h02, 32'h1234_5678), 1'b1, 1'b1};
    vecs[3] = '{mk(4'hF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFF), 1'b1, 1'b1};
    vecs[4] = '{mk(4'h0, 8'h01, 8'h02, 8'h03, 32'h99), 1'b0, 1'b0};
    f = mk(4'h1, 8'h01, 8'h02, 8'h02, 32'h77); f[81] = 1'b0;
    vecs[5] = '{f, 1'b1, 1'b0};
    f = mk(4'h0, 8'h09, 8'h08, 8'h07, 32'hCAFE); f[40] = 1'b1; f[52] = 1'b1;
    vecs[6] = '{f, 1'b1, 1'b1};

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_int("reset_host_valid", int'(host_valid), 0);
    check_flit("reset_host_flit", host_flit, '0);
    check_int("reset_drop_err", int'(drop_err), 0);
    check_int("reset_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;

    // PASS forward with one-cycle latency and single-cycle valid.
    host_ready = 1'b1;
    f = mk(4'h0, 8'h03, 8'h01, 8'h00, 32'h6);
    exp_q.push_back(f);
    send(f);
    idle();
    check_int("pass_valid_next_cycle", int'(host_valid), 1);
    check_flit("pass_flit", host_flit, f);
    @(posedge clk);
    #1;
    check_int("pass_valid_one_cycle", int'(host_valid), 0);

    // Table of single flits.
    cfg_expected = 8'd4;
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].exp_out) exp_q.push_back(vecs[i].flit);
      drive(vecs[i].flit, vecs[i].valid);
    end
    idle();
    drain();
    check_int("table_busy_idle", int'(busy), 0);

    // RSUM over four contributions.
    cfg_expected = 8'd4;
    exp_q.push_back(mk(4'h1, NODE, 8'h21, 8'h05, 32'd18));
    send(mk(4'h1, 8'h01, 8'h21, 8'h05, 32'd6));
    send(mk(4'h1, 8'h02, 8'h21, 8'h05, 32'd5));
    check_int("rsum_busy_mid", int'(busy), 1);
    send(mk(4'h1, 8'h03, 8'h21, 8'h05, 32'd4));
    send(mk(4'h1, 8'h04, 8'h21, 8'h05, 32'd3));
    check_int("rsum_no_early_output", int'(host_valid), 0);
    idle();
    check_int("rsum_valid_after_last", int'(host_valid), 1);
    check_int("rsum_busy_after", int'(busy), 0);
    drain();

    // RMAX with interleaved tags.
    cfg_expected = 8'd2;
    send(mk(4'h2, 8'h01, 8'h31, 8'h01, 32'd9));
    send(mk(4'h2, 8'h01, 8'h32, 8'h02, 32'd7));
    exp_q.push_back(mk(4'h2, NODE, 8'h31, 8'h01, 32'd9));
    send(mk(4'h2, 8'h02, 8'h31, 8'h01, 32'd3));
    exp_q.push_back(mk(4'h2, NODE, 8'h32, 8'h02, 32'd11));
    send(mk(4'h2, 8'h02, 8'h32, 8'h02, 32'd11));
    idle();
    drain();

    // Boundaries: cfg 0 acts as 1, RSUM wraps mod 2^32, RMAX is unsigned.
    cfg_expected = 8'd0;
    exp_q.push_back(mk(4'h1, NODE, 8'h40, 8'h03, 32'h1234));
    send(mk(4'h1, 8'h07, 8'h40, 8'h03, 32'h1234));
    idle();
    check_int("cfg0_busy", int'(busy), 0);
    drain();
    cfg_expected = 8'd2;
    send(mk(4'h1, 8'h07, 8'h41, 8'h06, 32'hFFFF_FFFF));
    exp_q.push_back(mk(4'h1, NODE, 8'h41, 8'h06, 32'h1));
    send(mk(4'h1, 8'h07, 8'h41, 8'h06, 32'h2));
    send(mk(4'h2, 8'h07, 8'h42, 8'h07, 32'h8000_0000));
    exp_q.push_back(mk(4'h2, NODE, 8'h42, 8'h07, 32'h8000_0000));
    send(mk(4'h2, 8'h07, 8'h42, 8'h07, 32'h5));
    idle();
    drain();

    // Overflow with host stalled.
    do_reset();
    host_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pf[i] = mk(4'h0, 8'h10, 8'h20, 8'(i), 32'(100 + i));
      if (i < 4) exp_q.push_back(pf[i]);
    end
    for (int i = 0; i < 5; i++) send(pf[i]);
    check_int("ovf_no_drop_at_four", int'(drop_err), 0);
    idle();
    check_int("ovf_drop_err", int'(drop_err), 1);
    check_flit("ovf_head_first", host_flit, pf[0]);
    pc0 = pop_count;
    @(posedge clk);
    #1;
    host_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_int("ovf_pop_count", pop_count - pc0, 4);
    check_int("ovf_valid_low", int'(host_valid), 0);
    check_int("ovf_queue_empty", exp_q.size(), 0);
    check_int("ovf_drop_sticky", int'(drop_err), 1);

    // Full FIFO with a simultaneous pop accepts the push.
    do_reset();
    host_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pf[i] = mk(4'h0, 8'h30, 8'h40, 8'(i), 32'(200 + i));
      exp_q.push_back(pf[i]);
    end
    for (int i = 0; i < 4; i++) send(pf[i]);
    @(posedge clk);
    #1;
    host_ready       = 1'b1;
    eject_xpos       = pf[4];
    eject_xpos_valid = 1'b1;
    idle();
    check_int("fullpop_no_drop", int'(drop_err), 0);
    drain();
    check_int("fullpop_drop_still_zero", int'(drop_err), 0);

    // Reset mid-reduction clears partial state immediately.
    cfg_expected = 8'd4;
    host_ready   = 1'b0;
    send(mk(4'h0, 8'h01, 8'h02, 8'h09, 32'h55));
    send(mk(4'h1, 8'h01, 8'h50, 8'h00, 32'd100));
    send(mk(4'h1, 8'h01, 8'h50, 8'h00, 32'd200));
    idle();
    check_int("mid_busy_before", int'(busy), 1);
    check_int("mid_valid_before", int'(host_valid), 1);
    #2;
    rst = 1'b0;
    #1;
    check_int("mid_reset_busy", int'(busy), 0);
    check_int("mid_reset_valid", int'(host_valid), 0);
    check_flit("mid_reset_flit", host_flit, '0);
    check_int("mid_reset_drop", int'(drop_err), 0);
    exp_q.delete();
    @(negedge clk);
    rst        = 1'b1;
    host_ready = 1'b1;
    exp_q.push_back(mk(4'h1, NODE, 8'h50, 8'h00, 32'd4));
    for (int i = 0; i < 4; i++) send(mk(4'h1, 8'h02, 8'h50, 8'h00, 32'd1));
    idle();
    drain();
    check_int("final_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
